bus_slave_port: RTL and testbench

- Serial-bus target stage directly downstream of the bus master.
- Receives the 16-bit address bit-serially and decodes the device-select field. For a matching device it acknowledges, then either receives 8 write bits or transmits 8 read bits.
- Presents a parallel single-cycle strobe interface to a local register/memory block.
- One instance per slave device on the shared bus.

---
 rtl/bus_slave_port_if.sv | 20 ++
 rtl/bus_slave_port.sv | 161 ++++++++++++++++
 tb/tb_bus_slave_port.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus_slave_port_if.sv
// rtl/bus_slave_port_if.sv - serial bus signals between the bus master and one slave port
interface bus_slave_port_if;
  logic B_UTIL;
  logic A_ADD;
  logic B_RW;
  logic B_BUS_IN;
  logic B_BUS_OUT;
  logic B_OUT_EN;
  logic B_ACK;

  modport master (
    output B_UTIL, A_ADD, B_RW, B_BUS_IN,
    input  B_BUS_OUT, B_OUT_EN, B_ACK
  );

  modport slave (
    input  B_UTIL, A_ADD, B_RW, B_BUS_IN,
    output B_BUS_OUT, B_OUT_EN, B_ACK
  );
endinterface

// File: rtl/bus_slave_port.sv
// rtl/bus_slave_port.sv - serial bus target: address decode, ack, 8-bit write/read
// with a single-cycle strobe interface to a local register block
module bus_slave_port #(
  parameter int                 DEV_W   = 4,
  parameter logic [DEV_W-1:0]   DEV_ID  = 4'b1010,
  parameter int                 LADDR_W = 12,
  parameter int                 DATA_W  = 8
) (
  input  logic               CLK,
  input  logic               RST,
  bus_slave_port_if.slave    bus,
  output logic [LADDR_W-1:0] S_ADDR,
  output logic [DATA_W-1:0]  S_WDATA,
  output logic               S_WE,
  output logic               S_RE,
  input  logic [DATA_W-1:0]  S_RDATA
);

  localparam int ADDR_W = DEV_W + LADDR_W;
  localparam int DCNT_W = $clog2(DATA_W);
  localparam logic [3:0]        ACNT_LAST = 4'(ADDR_W - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, RX, ACK_D, TX, WAIT_END
  } state_t;

  state_t              state, state_nx;
  logic [3:0]          acnt;
  logic [DCNT_W-1:0]   dcnt;
  logic                ack_ph;
  logic                rw;
  logic [ADDR_W-2:0]   addr_sr;
  logic [ADDR_W-1:0]   addr_nx;
  logic                dev_match;
  logic [DATA_W-1:0]   rx_sr;
  logic [DATA_W-1:0]   tx_sr;
  logic [LADDR_W-1:0]  s_addr_q;
  logic                b_ack, b_out_en, b_bus_out, s_we, s_re;

  // The top address bit never needs storing: it leaves the register as bit 0 arrives.
  assign addr_nx   = {addr_sr, bus.B_BUS_IN};
  assign dev_match = (addr_nx[ADDR_W-1 -: DEV_W] == DEV_ID);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (bus.B_UTIL && bus.A_ADD) state_nx = ADDR;
      ADDR: begin
        if (!bus.B_UTIL || !bus.A_ADD) state_nx = WAIT_END;
        else if (acnt == ACNT_LAST)    state_nx = dev_match ? ACK_A : WAIT_END;
      end
      ACK_A: begin
        if (!bus.B_UTIL) state_nx = IDLE;
        else if (ack_ph) state_nx = rw ? RX : TX;
      end
      RX: begin
        if (!bus.B_UTIL)             state_nx = IDLE;
        else if (dcnt == DCNT_LAST)  state_nx = ACK_D;
      end
      ACK_D: begin
        if (!bus.B_UTIL) state_nx = IDLE;
        else if (ack_ph) state_nx = WAIT_END;
      end
      TX: begin
        if (!bus.B_UTIL)             state_nx = IDLE;
        else if (dcnt == DCNT_LAST)  state_nx = WAIT_END;
      end
      WAIT_END: if (!bus.B_UTIL) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acnt     <= '0;
      dcnt     <= '0;
      ack_ph   <= 1'b0;
      rw       <= 1'b0;
      addr_sr  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      s_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_ph <= 1'b0;
          dcnt   <= '0;
          if (bus.B_UTIL && bus.A_ADD) begin
            addr_sr <= {{(ADDR_W-2){1'b0}}, bus.B_BUS_IN};
            acnt    <= 4'd1;
          end
        end
        ADDR: begin
          if (bus.B_UTIL && bus.A_ADD) begin
            addr_sr <= addr_nx[ADDR_W-2:0];
            acnt    <= acnt + 1'b1;
            if (acnt == ACNT_LAST) begin
              rw <= bus.B_RW;
              if (dev_match) s_addr_q <= addr_nx[LADDR_W-1:0];
            end
          end
        end
        ACK_A: begin
          ack_ph <= ~ack_ph;
          dcnt   <= '0;
          // Read data is valid in the second ack cycle, one cycle after S_RE.
          if (ack_ph && !rw) tx_sr <= S_RDATA;
        end
        RX: begin
          rx_sr <= {rx_sr[DATA_W-2:0], bus.B_BUS_IN};
          dcnt  <= dcnt + 1'b1;
        end
        ACK_D: ack_ph <= ~ack_ph;
        TX: begin
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
          dcnt  <= dcnt + 1'b1;
        end
        default: ;
      endcase
      if (state_nx == IDLE) s_addr_q <= '0;
    end
  end

  always_comb begin
    b_ack     = 1'b0;
    b_out_en  = 1'b0;
    b_bus_out = 1'b0;
    s_we      = 1'b0;
    s_re      = 1'b0;
    case (state)
      ACK_A: begin
        b_ack = 1'b1;
        s_re  = !ack_ph && !rw;
      end
      ACK_D: begin
        b_ack = 1'b1;
        s_we  = !ack_ph;
      end
      TX: begin
        b_out_en  = 1'b1;
        b_bus_out = tx_sr[DATA_W-1];
      end
      default: ;
    endcase
  end

  assign bus.B_ACK     = b_ack;
  assign bus.B_OUT_EN  = b_out_en;
  assign bus.B_BUS_OUT = b_bus_out;
  assign S_WE          = s_we;
  assign S_RE          = s_re;
  assign S_ADDR        = s_addr_q;
  assign S_WDATA       = rx_sr;

endmodule

// File: tb/tb_bus_slave_port.sv
// tb/tb_bus_slave_port.sv - self-checking bench for bus_slave_port
module tb_bus_slave_port;

  logic        CLK = 1'b0;
  logic        RST;
  logic [11:0] s_addr;
  logic [7:0]  s_wdata;
  logic [7:0]  s_rdata;
  logic        s_we, s_re;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;

  bus_slave_port_if bif ();

  bus_slave_port #(
    .DEV_W(4), .DEV_ID(4'b1010), .LADDR_W(12), .DATA_W(8)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bif),
    .S_ADDR(s_addr), .S_WDATA(s_wdata), .S_WE(s_we), .S_RE(s_re), .S_RDATA(s_rdata)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          abort_cyc;
    int          rst_cyc;
    int          hold;
    logic        exp_match;
    int          exp_we;
  } vec_t;

  task automatic chk(input string what, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", what, c, got, exp);
    end
  endtask

  // Transaction timeline: cycle 1 carries address bit 15, 16 carries bit 0, acks in 17-18,
  // data bits in 19-26, write-completion acks in 27-28.
  task automatic run_txn(input logic [15:0] addr, input logic rw, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int abort_cyc, input int rst_cyc,
                         input int hold, input logic exp_match, input int exp_we, input string nm);
    int len, active_end, total, we_seen;
    logic re_prev, live, ack_e, re_e, oe_e, bo_e, we_e;
    logic [4:0] got, exp;
    len = !exp_match ? 16 : (rw ? 28 : 26);
    if (abort_cyc > 0)    active_end = abort_cyc - 1;
    else if (rst_cyc > 0) active_end = rst_cyc;
    else                  active_end = len + hold;
    total   = (abort_cyc > 0) ? abort_cyc + 1 : active_end + 1;
    we_seen = 0;
    re_prev = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(posedge CLK); #1;
      RST          = (c == rst_cyc);
      bif.B_UTIL   = (c <= active_end);
      bif.A_ADD    = (c <= 16) ? 1'b1 : 1'($urandom);
      bif.B_BUS_IN = (c <= 16) ? addr[16-c] :
                     (rw && c >= 19 && c <= 26) ? wdata[26-c] : 1'($urandom);
      bif.B_RW     = (c == 16) ? rw : 1'($urandom);
      s_rdata      = re_prev ? rdata : 8'($urandom);
      @(negedge CLK);
      live  = exp_match && (abort_cyc == 0 || c <= abort_cyc) && (rst_cyc == 0 || c <= rst_cyc);
      ack_e = live && (c == 17 || c == 18 || (rw && (c == 27 || c == 28)));
      re_e  = live && !rw && c == 17;
      oe_e  = live && !rw && c >= 19 && c <= 26;
      bo_e  = oe_e ? rdata[26-c] : 1'b0;
      we_e  = live && rw && c == 27;
      exp = {ack_e, oe_e, bo_e, we_e, re_e};
      got = {bif.B_ACK, bif.B_OUT_EN, bif.B_BUS_OUT, s_we, s_re};
      chk({nm, " ack/oe/out/we/re"}, c, 32'(got), 32'(exp));
      if (ack_e) chk({nm, " S_ADDR"}, c, 32'(s_addr), 32'(addr[11:0]));
      if (we_e)  chk({nm, " S_WDATA"}, c, 32'(s_wdata), 32'(wdata));
      if (rst_cyc > 0 && c == rst_cyc + 1)
        chk({nm, " after-reset addr/wdata"}, c, 32'({s_addr, s_wdata}), 32'h0);
      we_seen += int'(s_we);
      re_prev  = s_re;
    end
    chk({nm, " S_WE pulse count"}, total, 32'(we_seen), 32'(exp_we));
    RST = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   len, abort_c, rst_c;
    logic [15:0] a;
    logic r, m;

    tbl[0]  = '{16'hA3C5, 1'b1, 8'hAD, 8'h00,  0,  0, 2, 1'b1, 1};
    tbl[1]  = '{16'hA0F0, 1'b0, 8'h00, 8'hB5,  0,  0, 1, 1'b1, 0};
    tbl[2]  = '{16'h53C5, 1'b1, 8'h11, 8'h00,  0,  0, 3, 1'b0, 0};
    tbl[3]  = '{16'hA3C5, 1'b1, 8'h77, 8'h00, 23,  0, 0, 1'b1, 0};
    tbl[4]  = '{16'hA001, 1'b1, 8'h5A, 8'h00,  0,  0, 1, 1'b1, 1};
    tbl[5]  = '{16'hA0F0, 1'b0, 8'h00, 8'hB5,  0, 21, 0, 1'b1, 0};
    tbl[6]  = '{16'hA0F0, 1'b0, 8'h00, 8'hB5,  0,  0, 0, 1'b1, 0};
    tbl[7]  = '{16'hA123, 1'b1, 8'h3C, 8'h00,  0,  0, 0, 1'b1, 1};
    tbl[8]  = '{16'hA456, 1'b1, 8'hC3, 8'h00,  0,  0, 0, 1'b1, 1};
    tbl[9]  = '{16'hA7FF, 1'b1, 8'h81, 8'h00, 27,  0, 0, 1'b1, 1};
    tbl[10] = '{16'hA010, 1'b0, 8'h00, 8'h6E, 17,  0, 0, 1'b1, 0};
    tbl[11] = '{16'hA0AA, 1'b1, 8'hFF, 8'h00,  9,  0, 0, 1'b1, 0};

    RST          = 1'b1;
    bif.B_UTIL   = 1'b1;
    bif.A_ADD    = 1'b1;
    bif.B_RW     = 1'b1;
    bif.B_BUS_IN = 1'b1;
    s_rdata      = 8'hFF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset outputs", 0,
        32'({bif.B_ACK, bif.B_OUT_EN, bif.B_BUS_OUT, s_we, s_re}), 32'h0);
    chk("reset addr/wdata", 0, 32'({s_addr, s_wdata}), 32'h0);
    @(posedge CLK); #1;
    RST        = 1'b0;
    bif.B_UTIL = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 12; i++)
      run_txn(tbl[i].addr, tbl[i].rw, tbl[i].wdata, tbl[i].rdata, tbl[i].abort_cyc,
              tbl[i].rst_cyc, tbl[i].hold, tbl[i].exp_match, tbl[i].exp_we,
              $sformatf("tbl%0d", i));

    for (int i = 0; i < 48; i++) begin
      a[15:12] = ($urandom_range(0, 9) < 6) ? 4'hA : 4'($urandom);
      a[11:0]  = 12'($urandom);
      r        = 1'($urandom);
      m        = (a[15:12] == 4'hA);
      len      = !m ? 16 : (r ? 28 : 26);
      abort_c  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, len)) : 0;
      rst_c    = (abort_c == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(2, len)) : 0;
      run_txn(a, r, 8'($urandom), 8'($urandom), abort_c, rst_c, int'($urandom_range(0, 3)), m,
              (m && r && (abort_c == 0 || abort_c >= 27) && (rst_c == 0 || rst_c >= 27)) ? 1 : 0,
              $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
